alu_mc: RTL and testbench
=========================

# alu_mc

Parametrised multi-cycle ALU and the next generation of the processor's single-cycle ALU. It keeps the ten one-hot integer operations and adds iterative unsigned multiply, divide and remainder. Operand width is set by a parameter. Operations are accepted and results returned through valid/ready handshakes, so the multi-cycle CPU datapath can stall on long operations. It sits in the EX stage between the operand muxes and the write-back register.

## Interface
- DATA_WIDTH, 32, operand and result width; must be a power of two, ≥ 8
- SHAMT_W, $clog2(DATA_WIDTH), shift-amount width (derived; do not override)

- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operation request valid
- in_ready  out  1  block can accept an operation
- A  in  DATA_WIDTH  operand A
- B  in  DATA_WIDTH  operand B
- alu_op  in  14  one-hot operation select:
  - bit 0 ADD, 1 SUB, 2 SLT, 3 SLTU, 4 AND, 5 OR, 6 XOR, 7 SLL, 8 SRL, 9 SRA
  - bit 10 MUL (low half), 11 MULHU (high half, unsigned), 12 DIVU, 13 REMU
- out_valid  out  1  Result/Zero valid
- out_ready  in  1  consumer takes the result
- Result  out  DATA_WIDTH  registered result
- Zero  out  1  registered; 1 when Result == 0
- busy  out  1  1 while an iterative operation is in progress

## Operation
- FSM has three states: IDLE, BUSY, DONE.
- **Accept.** An operation is accepted when in_valid && in_ready. in_ready = (state == IDLE) && !rst.
- **Operand capture.** A, B and alu_op are captured at accept. Later changes on these inputs are ignored until the next accept.
- **Op select.**
  - If more than one op bit is set, the lowest set bit wins.
  - All-zero alu_op gives Result = 0 on the single-cycle path.
- **Single-cycle ops (bits 0–9, or all-zero).**
  - Result is computed from the captured operands and registered at accept.
  - State goes IDLE → DONE.
- **Arithmetic rules (single-cycle ops).**
  - ADD and SUB wrap modulo 2^DATA_WIDTH.
  - SLT is a signed compare and is correct on overflow; SLTU is unsigned. Both give 0 or 1, zero-extended.
  - Shifts use B[SHAMT_W-1:0] only. SRA replicates A[DATA_WIDTH-1].
- **Iterative ops (bits 10–13).** State goes IDLE → BUSY and a cycle counter loads 0.
  - MUL/MULHU: shift-add, one multiplier bit per cycle, with a 2·DATA_WIDTH accumulator. MUL returns the low half; MULHU returns the high half.
  - DIVU/REMU: restoring division, one quotient bit per cycle.
  - Divide by zero: DIVU returns all-ones and REMU returns A. It takes the same latency and raises no error.
  - BUSY lasts exactly DATA_WIDTH cycles. On the last count the Result register loads and state goes BUSY → DONE.
- **DONE.**
  - out_valid = 1, and Result/Zero are held stable until out_ready.
  - On out_valid && out_ready, state goes DONE → IDLE.
  - If out_ready is low, DONE holds indefinitely with no change.
- **No overlap.** No new operation is accepted in BUSY or DONE (in_ready = 0).
- **Zero** is registered together with Result, as (next Result == 0).

## Timing
- **Reset values** (cycle after rst is sampled high):
  - state IDLE, out_valid 0, busy 0
  - Result 0, Zero 1, counter 0
  - in_ready 0 while rst is high, 1 in the first cycle after rst falls
- **Reset mid-operation** (BUSY or DONE): the operation is discarded, no out_valid is produced, and state returns to IDLE.
- **Single-cycle latency:** accept at edge T → out_valid high after T, i.e. 1 cycle.
- **Iterative latency:** accept at T → busy high from T to T+DATA_WIDTH → out_valid after T+DATA_WIDTH, i.e. DATA_WIDTH+1 cycles.
- **Back-to-back throughput:** with out_ready held at 1, the earliest next accept is the cycle after the result handshake. Single-cycle ops therefore issue one every 2 cycles.
- out_ready asserted while out_valid = 0 has no effect.

## Test plan
- ADD 0x7FFFFFFF + 1 → Result 0x80000000, Zero 0, out_valid 1 cycle after accept. SUB 5 − 5 → Result 0, Zero 1.
- SLT A=0x80000000, B=1 → 1; SLTU with the same operands → 0. SRA A=0x80000000, B=0x24 (shamt 4) → 0xF8000000. SRL with the same operands → 0x08000000.
- MUL 0xFFFFFFFF × 0xFFFFFFFF → 0x00000001; MULHU with the same operands → 0xFFFFFFFE. busy is high exactly 32 cycles and out_valid rises 33 cycles after accept.
- DIVU 100/7 → 14 and REMU 100/7 → 2. DIVU x/0 → 0xFFFFFFFF and REMU 0x1234/0 → 0x1234, each with 33-cycle latency.
- Backpressure: hold out_ready = 0 for 10 cycles after a result → Result stable, in_ready 0, in_valid ignored. Raise out_ready → IDLE next cycle, then a new op is accepted.
- Assert rst at cycle 10 of a DIVU → no out_valid, and all outputs at reset values next cycle. DATA_WIDTH = 8 instance: MUL 0x10 × 0x10 → 0x00, MULHU → 0x01, 9-cycle latency.

Source files
------------

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle integer ALU with valid/ready handshakes on both sides.
//
// Single-cycle ops (ADD, SUB, SLT, SLTU, AND, OR, XOR, SLL, SRL, SRA) are
// computed at accept and presented one cycle later. MUL, MULHU, DIVU and
// REMU iterate one bit per cycle for DATA_WIDTH cycles before presenting.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operation request valid
//   in_ready   block can accept an operation (IDLE and not in reset)
//   A, B       operands, captured at accept
//   alu_op     one-hot op select; lowest set bit wins, all-zero gives 0
//   out_valid  Result/Zero valid (DONE state)
//   out_ready  consumer takes the result
//   Result     registered result
//   Zero       registered, 1 when Result == 0
//   busy       1 while an iterative operation is in progress
module alu_mc #(
  parameter int DATA_WIDTH = 32,
  parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic [13:0]           alu_op,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] Result,
  output logic                  Zero,
  output logic                  busy
);

  localparam logic [SHAMT_W-1:0] CNT_LAST = SHAMT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_reg, state_next;
  // hi/lo form the 2*DATA_WIDTH working register shared by both iterative
  // units: {partial high, multiplier/low product} for multiply and
  // {partial remainder, dividend/quotient} for divide.
  logic [DATA_WIDTH-1:0] hi_reg, hi_next;
  logic [DATA_WIDTH-1:0] lo_reg, lo_next;
  logic [DATA_WIDTH-1:0] b_reg, b_next;        // multiplicand or divisor
  logic                  is_mul_reg, is_mul_next;
  logic                  sel_low_reg, sel_low_next; // MUL/DIVU return lo half
  logic [SHAMT_W-1:0]    cnt_reg, cnt_next;
  logic [DATA_WIDTH-1:0] result_reg, result_next;
  logic                  zero_reg, zero_next;

  logic [13:0]           op_lsb;
  logic                  is_iter;
  logic                  accept;
  logic [SHAMT_W-1:0]    shamt;
  logic [DATA_WIDTH-1:0] single_result;

  logic [DATA_WIDTH:0]   mul_sum;
  logic [DATA_WIDTH:0]   div_shift;
  logic                  div_ge;
  logic [DATA_WIDTH-1:0] div_diff;
  logic [DATA_WIDTH-1:0] hi_step, lo_step, iter_result;

  // Single-cycle datapath. Isolating the lowest set bit makes the op select
  // one-hot, so multi-bit requests resolve to the lowest-numbered op.
  always_comb begin
    op_lsb        = alu_op & (~alu_op + 14'd1);
    is_iter       = |op_lsb[13:10];
    shamt         = B[SHAMT_W-1:0];
    single_result = '0;
    if (op_lsb[0]) single_result = A + B;
    if (op_lsb[1]) single_result = A - B;
    if (op_lsb[2]) single_result = {{(DATA_WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
    if (op_lsb[3]) single_result = {{(DATA_WIDTH-1){1'b0}}, (A < B)};
    if (op_lsb[4]) single_result = A & B;
    if (op_lsb[5]) single_result = A | B;
    if (op_lsb[6]) single_result = A ^ B;
    if (op_lsb[7]) single_result = A << shamt;
    if (op_lsb[8]) single_result = A >> shamt;
    if (op_lsb[9]) single_result = $unsigned($signed(A) >>> shamt);
  end

  // One iteration of shift-add multiply or restoring divide.
  always_comb begin
    mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, b_reg} : {(DATA_WIDTH+1){1'b0}});
    div_shift = {hi_reg, lo_reg[DATA_WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, b_reg});
    // When div_ge holds the true difference fits in DATA_WIDTH bits, so the
    // truncated subtraction is exact. A zero divisor always subtracts, which
    // naturally yields an all-ones quotient and a remainder equal to A.
    div_diff  = div_shift[DATA_WIDTH-1:0] - b_reg;
    if (is_mul_reg) begin
      hi_step = mul_sum[DATA_WIDTH:1];
      lo_step = {mul_sum[0], lo_reg[DATA_WIDTH-1:1]};
    end else begin
      hi_step = div_ge ? div_diff : div_shift[DATA_WIDTH-1:0];
      lo_step = {lo_reg[DATA_WIDTH-2:0], div_ge};
    end
    iter_result = sel_low_reg ? lo_step : hi_step;
  end

  // Next-state and datapath control.
  always_comb begin
    state_next   = state_reg;
    hi_next      = hi_reg;
    lo_next      = lo_reg;
    b_next       = b_reg;
    is_mul_next  = is_mul_reg;
    sel_low_next = sel_low_reg;
    cnt_next     = cnt_reg;
    result_next  = result_reg;
    zero_next    = zero_reg;
    in_ready     = (state_reg == IDLE) && !rst;
    accept       = in_valid && in_ready;

    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (is_iter) begin
            state_next   = BUSY;
            cnt_next     = '0;
            hi_next      = '0;
            is_mul_next  = op_lsb[10] | op_lsb[11];
            sel_low_next = op_lsb[10] | op_lsb[12];
            lo_next      = (op_lsb[10] | op_lsb[11]) ? B : A;
            b_next       = (op_lsb[10] | op_lsb[11]) ? A : B;
          end else begin
            state_next  = DONE;
            result_next = single_result;
            zero_next   = (single_result == '0);
          end
        end
      end
      BUSY: begin
        hi_next  = hi_step;
        lo_next  = lo_step;
        cnt_next = cnt_reg + SHAMT_W'(1);
        if (cnt_reg == CNT_LAST) begin
          state_next  = DONE;
          result_next = iter_result;
          zero_next   = (iter_result == '0);
        end
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      hi_reg      <= '0;
      lo_reg      <= '0;
      b_reg       <= '0;
      is_mul_reg  <= 1'b0;
      sel_low_reg <= 1'b0;
      cnt_reg     <= '0;
      result_reg  <= '0;
      zero_reg    <= 1'b1;
    end else begin
      state_reg   <= state_next;
      hi_reg      <= hi_next;
      lo_reg      <= lo_next;
      b_reg       <= b_next;
      is_mul_reg  <= is_mul_next;
      sel_low_reg <= sel_low_next;
      cnt_reg     <= cnt_next;
      result_reg  <= result_next;
      zero_reg    <= zero_next;
    end
  end

  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg == BUSY);
  assign Result    = result_reg;
  assign Zero      = zero_reg;

endmodule

// File: tb/tb_alu_mc.sv
// Directed testbench for alu_mc: a 32-bit instance covers all ops, latency,
// backpressure, back-to-back issue and mid-operation reset; an 8-bit
// instance covers the narrow multiply case.
module tb_alu_mc;

  localparam logic [13:0] OP_ADD   = 14'h0001;
  localparam logic [13:0] OP_SUB   = 14'h0002;
  localparam logic [13:0] OP_SLT   = 14'h0004;
  localparam logic [13:0] OP_SLTU  = 14'h0008;
  localparam logic [13:0] OP_AND   = 14'h0010;
  localparam logic [13:0] OP_OR    = 14'h0020;
  localparam logic [13:0] OP_XOR   = 14'h0040;
  localparam logic [13:0] OP_SLL   = 14'h0080;
  localparam logic [13:0] OP_SRL   = 14'h0100;
  localparam logic [13:0] OP_SRA   = 14'h0200;
  localparam logic [13:0] OP_MUL   = 14'h0400;
  localparam logic [13:0] OP_MULHU = 14'h0800;
  localparam logic [13:0] OP_DIVU  = 14'h1000;
  localparam logic [13:0] OP_REMU  = 14'h2000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, Zero, busy;
  logic [31:0] A = '0, B = '0, Result;
  logic [13:0] alu_op = '0;

  logic        iv8 = 1'b0, ir8, ov8, or8 = 1'b1, z8, busy8;
  logic [7:0]  a8 = '0, b8 = '0, res8;
  logic [13:0] op8 = '0;

  int checks = 0;
  int failures = 0;

  alu_mc #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .alu_op(alu_op), .out_valid(out_valid),
    .out_ready(out_ready), .Result(Result), .Zero(Zero), .busy(busy)
  );

  alu_mc #(.DATA_WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8),
    .A(a8), .B(b8), .alu_op(op8), .out_valid(ov8),
    .out_ready(or8), .Result(res8), .Zero(z8), .busy(busy8)
  );

  // Directed single-cycle vectors.
  logic [31:0] sc_a   [16] = '{32'h7FFFFFFF, 32'h5, 32'h80000000, 32'h80000000,
                               32'h80000000, 32'h80000000, 32'h0000F0F0, 32'h0000F0F0,
                               32'h0000F0F0, 32'h1, 32'h3, 32'h5, 32'h5, 32'h5,
                               32'h7FFFFFFF, 32'h7FFFFFFF};
  logic [31:0] sc_b   [16] = '{32'h1, 32'h5, 32'h1, 32'h1, 32'h24, 32'h24,
                               32'h0000FF00, 32'h0000FF00, 32'h0000FF00, 32'h21,
                               32'h5, 32'h3, 32'h3, 32'h3, 32'h80000000, 32'h80000000};
  logic [13:0] sc_op  [16] = '{OP_ADD, OP_SUB, OP_SLT, OP_SLTU, OP_SRA, OP_SRL,
                               OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SUB,
                               14'h0003, 14'h0402, 14'h0000, OP_SLT, OP_SLTU};
  logic [31:0] sc_exp [16] = '{32'h80000000, 32'h0, 32'h1, 32'h0, 32'hF8000000,
                               32'h08000000, 32'h0000F000, 32'h0000FFF0, 32'h00000FF0,
                               32'h2, 32'hFFFFFFFE, 32'h8, 32'h2, 32'h0, 32'h0, 32'h1};

  // Directed iterative vectors.
  logic [31:0] it_a   [11] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h3039, 32'h3039,
                               32'd100, 32'd100, 32'hDEADBEEF, 32'h1234, 32'd7,
                               32'hFFFFFFFF, 32'hFFFFFFFF};
  logic [31:0] it_b   [11] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h2A6, 32'h2A6,
                               32'd7, 32'd7, 32'h0, 32'h0, 32'd100, 32'h10, 32'h10};
  logic [13:0] it_op  [11] = '{OP_MUL, OP_MULHU, OP_MUL, OP_MULHU, OP_DIVU, OP_REMU,
                               OP_DIVU, OP_REMU, OP_DIVU, OP_REMU, OP_DIVU};
  logic [31:0] it_exp [11] = '{32'h1, 32'hFFFFFFFE, 32'h007FB6F6, 32'h0, 32'd14,
                               32'd2, 32'hFFFFFFFF, 32'h1234, 32'h0, 32'hF, 32'h0FFFFFFF};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one operation for a single edge (caller ensures in_ready), then
  // scrambles the inputs so a design that fails to capture them is exposed.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [13:0] op);
    A = a; B = b; alu_op = op; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    A = ~a; B = a ^ b ^ 32'h5A5A5A5A; alu_op = 14'h3FFF;
  endtask

  // Latency counts the accept edge as 1; bounded so it cannot hang.
  task automatic wait_result(output int lat, output int bcnt);
    lat = 1; bcnt = 0;
    while (!out_valid && lat < 100) begin
      if (busy) bcnt++;
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (Result !== 32'h0) begin failures++; $display("FAIL reset_result got %h want 0", Result); end
    checks++; if (Zero !== 1'b1) begin failures++; $display("FAIL reset_zero got %b want 1", Zero); end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL release_in_ready got %b want 1", in_ready); end
    step();
    $display("reset released");
  endtask

  task automatic test_single_cycle();
    int lat, bcnt;
    for (int i = 0; i < 16; i++) begin
      issue(sc_a[i], sc_b[i], sc_op[i]);
      wait_result(lat, bcnt);
      $display("op=%h A=%h B=%h -> Result=%h Zero=%b lat=%0d", sc_op[i], sc_a[i], sc_b[i], Result, Zero, lat);
      checks++; if (Result !== sc_exp[i]) begin failures++; $display("FAIL sc_result[%0d] got %h want %h", i, Result, sc_exp[i]); end
      checks++; if (Zero !== (sc_exp[i] == 32'h0)) begin failures++; $display("FAIL sc_zero[%0d] got %b want %b", i, Zero, sc_exp[i] == 32'h0); end
      checks++; if (lat != 1) begin failures++; $display("FAIL sc_latency[%0d] got %0d want 1", i, lat); end
      step();
    end
  endtask

  task automatic test_iterative();
    int lat, bcnt;
    for (int i = 0; i < 11; i++) begin
      issue(it_a[i], it_b[i], it_op[i]);
      wait_result(lat, bcnt);
      $display("op=%h A=%h B=%h -> Result=%h Zero=%b lat=%0d busy=%0d", it_op[i], it_a[i], it_b[i], Result, Zero, lat, bcnt);
      checks++; if (Result !== it_exp[i]) begin failures++; $display("FAIL it_result[%0d] got %h want %h", i, Result, it_exp[i]); end
      checks++; if (Zero !== (it_exp[i] == 32'h0)) begin failures++; $display("FAIL it_zero[%0d] got %b want %b", i, Zero, it_exp[i] == 32'h0); end
      checks++; if (lat != 33) begin failures++; $display("FAIL it_latency[%0d] got %0d want 33", i, lat); end
      checks++; if (bcnt != 32) begin failures++; $display("FAIL it_busy_cycles[%0d] got %0d want 32", i, bcnt); end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ea;
    logic        exp_ov;
    ea = 32'h1;
    A = ea; B = 32'h2; alu_op = OP_ADD; in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      exp_ov = (k % 2 == 0);
      checks++; if (out_valid !== exp_ov) begin failures++; $display("FAIL b2b_out_valid[%0d] got %b want %b", k, out_valid, exp_ov); end
      checks++; if (in_ready !== !exp_ov) begin failures++; $display("FAIL b2b_in_ready[%0d] got %b want %b", k, in_ready, !exp_ov); end
      if (exp_ov) begin
        $display("b2b op=ADD A=%h B=%h -> Result=%h", ea, 32'h2, Result);
        checks++; if (Result !== ea + 32'h2) begin failures++; $display("FAIL b2b_result[%0d] got %h want %h", k, Result, ea + 32'h2); end
        ea = ea + 32'h10;
        A = ea;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    int lat, bcnt;
    out_ready = 1'b0;
    issue(32'd10, 32'd20, OP_ADD);
    wait_result(lat, bcnt);
    in_valid = 1'b1; A = 32'h11111111; B = 32'h22222222; alu_op = OP_SUB;
    for (int k = 0; k < 10; k++) begin
      step();
      checks++; if (Result !== 32'd30 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold[%0d] got Result=%h out_valid=%b in_ready=%b want 0000001e/1/0", k, Result, out_valid, in_ready);
      end
    end
    in_valid = 1'b0;
    $display("backpressure held Result=%h for 10 cycles", Result);
    out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL bp_release got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    issue(32'd9, 32'd4, OP_SUB);
    wait_result(lat, bcnt);
    $display("op=SUB A=9 B=4 -> Result=%h lat=%0d", Result, lat);
    checks++; if (Result !== 32'd5 || lat != 1) begin
      failures++; $display("FAIL bp_next_op got Result=%h lat=%0d want 00000005 lat 1", Result, lat);
    end
    step();
  endtask

  task automatic test_reset_mid_op();
    int ov_count;
    issue(32'd100, 32'd7, OP_DIVU);
    for (int k = 0; k < 9; k++) step();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_busy got %b want 1", busy); end
    rst = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      failures++; $display("FAIL mid_reset_ctrl got out_valid=%b busy=%b in_ready=%b want 0/0/0", out_valid, busy, in_ready);
    end
    checks++; if (Result !== 32'h0 || Zero !== 1'b1) begin
      failures++; $display("FAIL mid_reset_result got Result=%h Zero=%b want 0/1", Result, Zero);
    end
    rst = 1'b0;
    ov_count = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (out_valid) ov_count++;
    end
    $display("reset during DIVU: out_valid pulses afterwards=%0d", ov_count);
    checks++; if (ov_count != 0) begin failures++; $display("FAIL mid_no_result got %0d want 0", ov_count); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_idle got in_ready=%b want 1", in_ready); end
  endtask

  task automatic test_width8();
    logic [13:0] ops [2] = '{OP_MUL, OP_MULHU};
    logic [7:0]  exps [2] = '{8'h00, 8'h01};
    int lat, bcnt;
    for (int i = 0; i < 2; i++) begin
      a8 = 8'h10; b8 = 8'h10; op8 = ops[i]; iv8 = 1'b1;
      step();
      iv8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF;
      lat = 1; bcnt = 0;
      while (!ov8 && lat < 50) begin
        if (busy8) bcnt++;
        step();
        lat++;
      end
      $display("w8 op=%h A=10 B=10 -> Result=%h Zero=%b lat=%0d busy=%0d", ops[i], res8, z8, lat, bcnt);
      checks++; if (res8 !== exps[i]) begin failures++; $display("FAIL w8_result[%0d] got %h want %h", i, res8, exps[i]); end
      checks++; if (z8 !== (exps[i] == 8'h00)) begin failures++; $display("FAIL w8_zero[%0d] got %b want %b", i, z8, exps[i] == 8'h00); end
      checks++; if (lat != 9 || bcnt != 8) begin failures++; $display("FAIL w8_latency[%0d] got lat=%0d busy=%0d want 9/8", i, lat, bcnt); end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_single_cycle();
    test_iterative();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_op();
    test_width8();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
